wb_conbus_rr: RTL

Parametrised Wishbone shared-bus interconnect. It connects N_MASTERS masters to N_SLAVES slaves through one shared path and arbitrates round-robin. It replaces the fixed 2-master/8-slave interconnect in the system top level. It adds configurable master and slave counts, a packed slave address map, an internal error responder for unmapped addresses, and an optional bus-timeout watchdog.

---
 rtl/wb_conbus_rr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_conbus_rr.sv
// Round-robin Wishbone shared-bus interconnect: N masters, N slaves, packed tag decode, error responder.
// Optional WB_CONBUS_TIMEOUT_EN adds a watchdog that errors out a transfer stalled for TIMEOUT_CYCLES.
module wb_conbus_rr #(
    parameter int N_MASTERS      = 2,
    parameter int N_SLAVES       = 8,
    parameter int S_ADDR_W       = 4,
    parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDRS = 32'h8765_4320,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS*32-1:0]   m_dat_i,
    input  logic [N_MASTERS*32-1:0]   m_adr_i,
    input  logic [N_MASTERS*4-1:0]    m_sel_i,
    input  logic [N_MASTERS-1:0]      m_we_i,
    input  logic [N_MASTERS-1:0]      m_cyc_i,
    input  logic [N_MASTERS-1:0]      m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [N_MASTERS-1:0]      m_ack_o,
    output logic [N_MASTERS-1:0]      m_err_o,
    input  logic [N_SLAVES*32-1:0]    s_dat_i,
    input  logic [N_SLAVES-1:0]       s_ack_i,
    output logic [31:0]               s_dat_o,
    output logic [31:0]               s_adr_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [N_SLAVES-1:0]       s_cyc_o,
    output logic [N_SLAVES-1:0]       s_stb_o,
    output logic [N_MASTERS-1:0]      grant_o
);
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    if (N_MASTERS < 1 || N_MASTERS > 8 || N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_conbus_rr: parameter out of range");
    end

    logic          grant_valid, nxt_valid;
    logic [MW-1:0] grant_idx, nxt_idx;
    logic          cur_cyc, cur_stb, cur_we;
    logic [31:0]   cur_adr, cur_dat;
    logic [3:0]    cur_sel;
    logic          hit;
    logic [SW-1:0] sel_slave;
    logic          err_q, to_fire, err_now, ack_raw, ack_now;

    // Search order starts just after the last owner; iterating backwards lets the nearest requester win.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_idx   = grant_idx;
        for (int k = N_MASTERS; k >= 1; k--) begin
            if (m_cyc_i[(int'(grant_idx) + k) % N_MASTERS]) begin
                nxt_valid = 1'b1;
                nxt_idx   = MW'((int'(grant_idx) + k) % N_MASTERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_valid <= 1'b0;
            grant_idx   <= MW'(N_MASTERS - 1);
        end else if (!grant_valid || !m_cyc_i[grant_idx]) begin
            grant_valid <= nxt_valid;
            grant_idx   <= nxt_idx;
        end
    end

    always_comb begin
        cur_cyc = 1'b0;
        cur_stb = 1'b0;
        cur_we  = 1'b0;
        cur_adr = '0;
        cur_dat = '0;
        cur_sel = '0;
        if (grant_valid) begin
            cur_cyc = m_cyc_i[grant_idx];
            cur_stb = m_stb_i[grant_idx];
            cur_we  = m_we_i[grant_idx];
            cur_adr = m_adr_i[grant_idx*32 +: 32];
            cur_dat = m_dat_i[grant_idx*32 +: 32];
            cur_sel = m_sel_i[grant_idx*4 +: 4];
        end
    end

    // Descending scan so that the lowest matching slave index is the one kept.
    always_comb begin
        hit       = 1'b0;
        sel_slave = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (cur_cyc && cur_adr[31 -: S_ADDR_W] == S_ADDRS[i*S_ADDR_W +: S_ADDR_W]) begin
                hit       = 1'b1;
                sel_slave = SW'(i);
            end
        end
    end

    assign ack_raw = hit & s_ack_i[sel_slave];

    // Unmapped strobe: one-cycle error, then a forced gap before it can fire again.
    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= cur_cyc & cur_stb & ~hit & ~err_q;
    end

`ifdef WB_CONBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    assign to_fire = hit && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst || !(cur_cyc && cur_stb) || ack_raw || err_q || to_fire) to_cnt <= '0;
        else                                                              to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_fire = 1'b0;
`endif

    assign err_now = err_q | to_fire;
    assign ack_now = ack_raw & ~err_now;

    always_comb begin
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        s_dat_o = '0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = '0;
        s_stb_o = '0;
        grant_o = '0;
        if (rst) begin
            s_dat_o = cur_dat;
            s_adr_o = cur_adr;
            s_sel_o = cur_sel;
            s_we_o  = cur_we;
            for (int i = 0; i < N_SLAVES; i++) begin
                s_cyc_o[i] = hit && !to_fire && (sel_slave == SW'(i));
                s_stb_o[i] = s_cyc_o[i] && cur_stb;
            end
            if (hit) m_dat_o = s_dat_i[sel_slave*32 +: 32];
            for (int k = 0; k < N_MASTERS; k++) begin
                grant_o[k] = grant_valid && (grant_idx == MW'(k));
                m_ack_o[k] = grant_o[k] && ack_now;
                m_err_o[k] = grant_o[k] && err_now;
            end
        end
    end
endmodule
